// File: rtl/sram_controller_if.sv
// sram_controller_if: bus-side and SRAM-chip-side bundles for the SRAM controller.
// The chip data pad is split into out/enable/in; the tristate buffer lives in the IO ring.
interface sram_bus_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] data_wr;
    logic [3:0]  mask;
    logic        stall;
    logic [31:0] data_rd;
    logic [31:0] data_rd_2;
    logic [5:0]  interrupt;
    modport master (output address, read, write, data_wr, mask,
                    input  stall, data_rd, data_rd_2, interrupt);
    modport slave  (input  address, read, write, data_wr, mask,
                    output stall, data_rd, data_rd_2, interrupt);
endinterface

interface sram_chip_if #(parameter int AW = 20);
    logic [AW-1:0] address;
    logic [31:0]   data_o;
    logic          data_oe;
    logic [31:0]   data_i;
    logic [3:0]    be_n;
    logic          ce_n;
    logic          oe_n;
    logic          we_n;
    modport master (output address, data_o, data_oe, be_n, ce_n, oe_n, we_n, input data_i);
    modport slave  (input  address, data_o, data_oe, be_n, ce_n, oe_n, we_n, output data_i);
endinterface

// File: rtl/sram_controller.sv
// sram_controller: bus slave turning single-cycle requests into timed async SRAM accesses.
// All chip-side outputs are registered; stall holds the master until the DONE cycle.
module sram_controller #(
    parameter int WAIT_STATES = 1,
    parameter int ADDR_WIDTH  = 20
) (
    input  logic       i_clk,
    input  logic       i_rst,
    sram_bus_if.slave  bus,
    sram_chip_if.master sram
);
    typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE} state_t;
    localparam logic [3:0] W = 4'(WAIT_STATES);
    state_t                r_state;
    logic [3:0]            r_cnt;
    logic                  r_ce_n;
    logic                  r_oe_n;
    logic                  r_we_n;
    logic [3:0]            r_be_n;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_data;
    logic                  r_doe;
    logic [31:0]           r_data_rd;
    logic                  w_req;
    assign w_req = bus.read | bus.write;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_ce_n    <= 1'b1;
            r_oe_n    <= 1'b1;
            r_we_n    <= 1'b1;
            r_be_n    <= 4'hF;
            r_addr    <= '0;
            r_data    <= '0;
            r_doe     <= 1'b0;
            r_data_rd <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // write wins when both requests arrive together
                    if (bus.write) begin
                        r_state <= WR_SETUP;
                        r_addr  <= bus.address[ADDR_WIDTH+1:2];
                        r_data  <= bus.data_wr;
                        r_be_n  <= ~bus.mask;
                        r_ce_n  <= 1'b0;
                        r_doe   <= 1'b1;
                    end else if (bus.read) begin
                        r_state <= RD;
                        r_addr  <= bus.address[ADDR_WIDTH+1:2];
                        r_cnt   <= W;
                        r_be_n  <= 4'h0;
                        r_ce_n  <= 1'b0;
                        r_oe_n  <= 1'b0;
                    end
                end
                RD: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state   <= DONE;
                        r_data_rd <= sram.data_i;
                        r_ce_n    <= 1'b1;
                        r_oe_n    <= 1'b1;
                        r_be_n    <= 4'hF;
                    end
                end
                WR_SETUP: begin
                    r_state <= WR_PULSE;
                    r_cnt   <= W;
                    r_we_n  <= 1'b0;
                end
                WR_PULSE: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state <= WR_HOLD;
                        r_we_n  <= 1'b1;
                    end
                end
                WR_HOLD: begin
                    // data stays driven one cycle past we_n rising for hold time
                    r_state <= DONE;
                    r_ce_n  <= 1'b1;
                    r_doe   <= 1'b0;
                    r_be_n  <= 4'hF;
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
    assign bus.stall     = w_req && (r_state != DONE);
    assign bus.data_rd   = r_data_rd;
    assign bus.data_rd_2 = '0;
    assign bus.interrupt = '0;
    assign sram.address  = r_addr;
    assign sram.data_o   = r_data;
    assign sram.data_oe  = r_doe;
    assign sram.be_n     = r_be_n;
    assign sram.ce_n     = r_ce_n;
    assign sram.oe_n     = r_oe_n;
    assign sram.we_n     = r_we_n;
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: two controllers (WAIT_STATES 1 and 0) on SRAM chip models,
// checked every cycle against a transaction-timeline reference model.
module tb_sram_controller;
    localparam int AW = 20;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    logic          rq_rd [2];
    logic          rq_wr [2];
    logic [31:0]   rq_addr [2];
    logic [31:0]   rq_wd [2];
    logic [3:0]    rq_m [2];
    logic          o_stall [2];
    logic [31:0]   o_drd [2];
    logic          o_we_n [2];
    logic          o_oe_n [2];
    logic          o_ce_n [2];
    logic          o_doe [2];
    logic [3:0]    o_be_n [2];
    logic [31:0]   o_dout [2];
    logic [AW-1:0] o_addr [2];
    int            mon_we [2];
    int            mon_oe [2];
    logic [3:0]    mon_be [2];
    logic [AW-1:0] mon_addr [2];

    task automatic chk(input string nm, input int g, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s inst%0d t=%0t got %h want %h", nm, g, $time, got, want);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : h
        localparam int W = (g == 0) ? 1 : 0;
        sram_bus_if bus ();
        sram_chip_if #(.AW(AW)) sif ();
        sram_controller #(.WAIT_STATES(W), .ADDR_WIDTH(AW)) dut (
            .i_clk(clk), .i_rst(rst), .bus(bus), .sram(sif));
        assign bus.read    = rq_rd[g];
        assign bus.write   = rq_wr[g];
        assign bus.address = rq_addr[g];
        assign bus.data_wr = rq_wd[g];
        assign bus.mask    = rq_m[g];
        assign o_stall[g]  = bus.stall;
        assign o_drd[g]    = bus.data_rd;
        assign o_we_n[g]   = sif.we_n;
        assign o_oe_n[g]   = sif.oe_n;
        assign o_ce_n[g]   = sif.ce_n;
        assign o_doe[g]    = sif.data_oe;
        assign o_be_n[g]   = sif.be_n;
        assign o_dout[g]   = sif.data_o;
        assign o_addr[g]   = sif.address;
        logic [31:0] mem [4096];
        assign sif.data_i = (!sif.ce_n && !sif.oe_n) ? mem[sif.address[11:0]] : 32'h0;
        initial begin
            for (int i = 0; i < 4096; i++) mem[i] = 32'(i) * 32'h9E3779B9;
            forever begin
                @(posedge clk);
                if (!sif.ce_n && !sif.we_n)
                    for (int b = 0; b < 4; b++)
                        if (!sif.be_n[b]) mem[sif.address[11:0]][8*b+:8] = sif.data_o[8*b+:8];
            end
        end
        int we_cnt = 0;
        int oe_cnt = 0;
        logic [3:0] be_s = 4'hF;
        logic [AW-1:0] addr_s = '0;
        always @(negedge clk) begin
            if (!sif.we_n) begin
                we_cnt <= we_cnt + 1;
                be_s   <= sif.be_n;
            end
            if (!sif.oe_n) oe_cnt <= oe_cnt + 1;
            if (!sif.ce_n) addr_s <= sif.address;
        end
        assign mon_we[g]   = we_cnt;
        assign mon_oe[g]   = oe_cnt;
        assign mon_be[g]   = be_s;
        assign mon_addr[g] = addr_s;
        // reference: position k within an access fixes every chip-side signal
        initial begin
            logic [31:0] ref_mem [4096];
            bit armed, busy, w, e_ce, e_oe, e_we, e_doe, e_stall;
            int c, t0, k, done_k;
            logic [31:0] la, ld, drd;
            logic [3:0] lm, e_be;
            armed = 0; busy = 0; w = 0; c = 0; t0 = 0; la = 0; ld = 0; drd = 0; lm = 0;
            for (int i = 0; i < 4096; i++) ref_mem[i] = 32'(i) * 32'h9E3779B9;
            forever begin
                @(negedge clk);
                c++;
                if (armed) begin
                    k = c - t0;
                    done_k = w ? W + 4 : W + 2;
                    if (busy && !w && k == done_k) drd = ref_mem[la[13:2]];
                    e_ce = 1; e_oe = 1; e_we = 1; e_doe = 0; e_be = 4'hF;
                    e_stall = rq_rd[g] | rq_wr[g];
                    if (busy && k < done_k) begin
                        e_ce = 0;
                        if (w) begin
                            e_doe = 1;
                            e_be = ~lm;
                            e_we = !(k >= 2 && k <= W + 2);
                        end else begin
                            e_oe = 0;
                            e_be = 4'h0;
                        end
                    end
                    if (busy && k == done_k) e_stall = 0;
                    chk("stall", g, o_stall[g], e_stall);
                    chk("ce_n", g, o_ce_n[g], e_ce);
                    chk("oe_n", g, o_oe_n[g], e_oe);
                    chk("we_n", g, o_we_n[g], e_we);
                    chk("data_oe", g, o_doe[g], e_doe);
                    chk("be_n", g, o_be_n[g], e_be);
                    chk("data_rd", g, o_drd[g], drd);
                    chk("oe_we_overlap", g, o_oe_n[g] | o_we_n[g], 1);
                    chk("drive_while_oe", g, o_doe[g] & !o_oe_n[g], 0);
                    if (!e_ce) chk("address", g, o_addr[g], la[AW+1:2]);
                    if (e_doe) chk("data_o", g, o_dout[g], ld);
                    if (busy && w && k == 2)
                        for (int b = 0; b < 4; b++)
                            if (lm[b]) ref_mem[la[13:2]][8*b+:8] = ld[8*b+:8];
                    if (busy && k == done_k) busy = 0;
                    else if (!busy && (rq_rd[g] | rq_wr[g])) begin
                        busy = 1; t0 = c; w = rq_wr[g];
                        la = rq_addr[g]; ld = rq_wd[g]; lm = rq_m[g];
                    end
                end
                if (rst) begin
                    armed = 1; busy = 0; drd = 0;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic access(input int g, input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] m, output int lat, output logic [31:0] rdata, output int dcyc);
        rq_rd[g] = rd; rq_wr[g] = wr; rq_addr[g] = a; rq_wd[g] = d; rq_m[g] = m;
        lat = 0;
        forever begin
            @(negedge clk);
            if (!o_stall[g]) break;
            lat++;
            if (lat > 40) begin
                checks++; errors++;
                $display("FAIL stall_timeout inst%0d got %0d cycles want <=40", g, lat);
                break;
            end
            @(posedge clk); #1;
        end
        rdata = o_drd[g];
        dcyc = cyc;
        @(posedge clk); #1;
        rq_rd[g] = 0; rq_wr[g] = 0;
    endtask

    task automatic rnd(input int g, input int n);
        int op, lat, dc;
        logic [31:0] a, rd;
        for (int i = 0; i < n; i++) begin
            op = $urandom_range(0, 4);
            a = ($urandom() & 32'hFFC00003) | (32'($urandom_range(0, 63)) << 2);
            if (op == 4) begin
                rq_addr[g] = a; rq_wd[g] = $urandom(); rq_m[g] = 4'($urandom());
                rq_wr[g] = 1'($urandom()); rq_rd[g] = !rq_wr[g];
                @(posedge clk); #1;
                rq_rd[g] = 0; rq_wr[g] = 0;
                idle(g == 0 ? 6 : 5);
            end else begin
                access(g, op == 0 || op == 3, op == 1 || op == 2 || op == 3, a, $urandom(), 4'($urandom()), lat, rd, dc);
            end
            idle($urandom_range(0, 2));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int lat, dc1, dc2, snap;
        logic [31:0] rd;
        for (int g = 0; g < 2; g++) begin
            rq_rd[g] = 0; rq_wr[g] = 0; rq_addr[g] = 0; rq_wd[g] = 0; rq_m[g] = 0;
        end
        rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk("rst_ce_n", g, o_ce_n[g], 1);
            chk("rst_we_n", g, o_we_n[g], 1);
            chk("rst_oe_n", g, o_oe_n[g], 1);
            chk("rst_be_n", g, o_be_n[g], 4'hF);
            chk("rst_addr", g, o_addr[g], 0);
            chk("rst_data_oe", g, o_doe[g], 0);
            chk("rst_data_rd", g, o_drd[g], 0);
        end
        chk("data_rd_2", 0, h[0].bus.data_rd_2, 0);
        chk("interrupt", 0, h[0].bus.interrupt, 0);
        @(posedge clk); #1;
        snap = mon_we[0];
        access(0, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, dc1);
        chk("t1_lat", 0, lat, 5);
        chk("t1_we_cycles", 0, mon_we[0] - snap, 2);
        chk("t1_addr", 0, mon_addr[0], 4);
        chk("t1_mem", 0, h[0].mem[4], 32'hDEADBEEF);
        snap = mon_oe[0];
        access(0, 1, 0, 32'h10, 0, 0, lat, rd, dc1);
        chk("t2_lat", 0, lat, 3);
        chk("t2_data", 0, rd, 32'hDEADBEEF);
        chk("t2_oe_cycles", 0, mon_oe[0] - snap, 2);
        access(0, 0, 1, 32'h20, 32'h11223344, 4'hF, lat, rd, dc1);
        access(0, 0, 1, 32'h20, 32'h000000AA, 4'h1, lat, rd, dc1);
        chk("t3_be_n", 0, mon_be[0], 4'hE);
        access(0, 1, 0, 32'h20, 0, 0, lat, rd, dc1);
        chk("t3_data", 0, rd, 32'h112233AA);
        access(0, 1, 1, 32'h30, 32'h55667788, 4'hF, lat, rd, dc1);
        chk("t4_lat", 0, lat, 5);
        chk("t4_data_rd_kept", 0, rd, 32'h112233AA);
        access(0, 1, 0, 32'h30, 0, 0, lat, rd, dc1);
        chk("t4_data", 0, rd, 32'h55667788);
        rq_addr[0] = 32'h40; rq_wd[0] = 32'hCAFEF00D; rq_m[0] = 4'hF; rq_wr[0] = 1;
        idle(2);
        rst = 1; rq_wr[0] = 0;
        idle(1);
        rst = 0;
        @(negedge clk);
        chk("t5_we_n", 0, o_we_n[0], 1);
        chk("t5_ce_n", 0, o_ce_n[0], 1);
        chk("t5_data_oe", 0, o_doe[0], 0);
        chk("t5_data_rd", 0, o_drd[0], 0);
        @(posedge clk); #1;
        access(0, 1, 0, 32'h10, 0, 0, lat, rd, dc1);
        chk("t5_mem_kept", 0, rd, 32'hDEADBEEF);
        access(1, 1, 0, 32'h0, 0, 0, lat, rd, dc1);
        access(1, 1, 0, 32'h4, 0, 0, lat, rd, dc2);
        chk("t6_lat", 1, lat, 2);
        chk("t6_done_gap", 1, dc2 - dc1, 3);
        chk("t6_data", 1, rd, 32'h9E3779B9);
        access(1, 1, 0, 32'hFFC00007, 0, 0, lat, rd, dc1);
        chk("hi_bits_addr", 1, mon_addr[1], 1);
        chk("hi_bits_data", 1, rd, 32'h9E3779B9);
        access(1, 0, 1, 32'h8, 32'hFFFFFFFF, 4'h0, lat, rd, dc1);
        chk("mask0_lat", 1, lat, 4);
        chk("mask0_be_n", 1, mon_be[1], 4'hF);
        access(1, 1, 0, 32'h8, 0, 0, lat, rd, dc1);
        chk("mask0_data", 1, rd, 32'h3C6EF372);
        fork
            rnd(0, 200);
            rnd(1, 200);
        join
        idle(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
